// File: rtl/alu_md_sequencer.sv
// ALU operation decoder (RV32I + RV32M) with a multi-cycle mul/div launch/stall sequencer.
// Define RV32M_EN to compile in MD decode and the sequencer; otherwise MD encodings decode as illegal.
module alu_md_sequencer #(
    parameter int SEL_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Valid,
    input  logic             Flush,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [1:0]       ALUOp,
    output logic [SEL_W-1:0] Selection,
    output logic             Illegal,
    output logic             Stall,
    output logic             MdStart,
    output logic [2:0]       MdOp,
    output logic             MdDone
);

    localparam logic [3:0] SEL_ADD  = 4'b0000;
    localparam logic [3:0] SEL_SUB  = 4'b0001;
    localparam logic [3:0] SEL_AND  = 4'b0010;
    localparam logic [3:0] SEL_OR   = 4'b0011;
    localparam logic [3:0] SEL_XOR  = 4'b0100;
    localparam logic [3:0] SEL_SLT  = 4'b0101;
    localparam logic [3:0] SEL_SLTU = 4'b0110;
    localparam logic [3:0] SEL_SLL  = 4'b0111;
    localparam logic [3:0] SEL_SRL  = 4'b1000;
    localparam logic [3:0] SEL_SRA  = 4'b1001;
    localparam logic [3:0] SEL_MD   = 4'b1010;
    localparam logic [3:0] SEL_ILL  = 4'b1111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic [3:0] decode_sel(
        input logic [1:0] aluop,
        input logic       op5,
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic       md_en
    );
        logic [3:0] sel;
        sel = SEL_ILL;
        case (aluop)
            2'b00: sel = SEL_ADD;
            2'b01: sel = SEL_SUB;
            2'b10: begin
                if (op5 && (f7 == F7_MULDIV)) begin
                    sel = md_en ? SEL_MD : SEL_ILL;
                end else begin
                    case (f3)
                        3'b000:  sel = (op5 && f7[5]) ? SEL_SUB : SEL_ADD;
                        3'b001:  sel = SEL_SLL;
                        3'b010:  sel = SEL_SLT;
                        3'b011:  sel = SEL_SLTU;
                        3'b100:  sel = SEL_XOR;
                        3'b101:  sel = f7[5] ? SEL_SRA : SEL_SRL;
                        3'b110:  sel = SEL_OR;
                        default: sel = SEL_AND;
                    endcase
                end
            end
            default: sel = SEL_ILL;
        endcase
        return sel;
    endfunction

    logic [3:0] sel4;

`ifdef RV32M_EN
    localparam logic MD_EN = 1'b1;
`else
    localparam logic MD_EN = 1'b0;
`endif

    assign sel4      = decode_sel(ALUOp, Op[5], funct3, funct7, MD_EN);
    assign Selection = SEL_W'(sel4);
    assign Illegal   = Valid && (sel4 == SEL_ILL);

`ifdef RV32M_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mdop_q, mdop_d;
    logic             mdstart_q, mdstart_d;
    logic             is_md;
    logic             launch;

    // A flush in the decode cycle cancels the launch entirely.
    assign is_md  = Valid && (sel4 == SEL_MD);
    assign launch = is_md && !Flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mdop_q    <= 3'b000;
            mdstart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mdop_q    <= mdop_d;
            mdstart_q <= mdstart_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mdop_d    = mdop_q;
        mdstart_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = RUN;
                    cnt_d     = funct3[2] ? DIV_LD : MUL_LD;
                    mdop_d    = funct3;
                    mdstart_d = 1'b1;
                end
            end
            RUN: begin
                if (Flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The launch-cycle stall is combinational, so it is gated by reset explicitly.
    assign Stall   = rst && (((state_q == IDLE) && launch) || (state_q == RUN));
    assign MdStart = mdstart_q;
    assign MdOp    = mdop_q;
    assign MdDone  = (state_q == DONE) && !Flush;

    logic unused_bits;
    assign unused_bits = &{1'b0, Op[6], Op[4:0]};
`else
    assign Stall   = 1'b0;
    assign MdStart = 1'b0;
    assign MdOp    = 3'b000;
    assign MdDone  = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, clk, rst, Flush, Op[6], Op[4:0]};
`endif

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Self-checking bench for alu_md_sequencer: randomized decode sweep plus mul/div sequencing
// scenarios checked against a cycle-timeline reference model; works with or without RV32M_EN.
module tb_alu_md_sequencer;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;
`ifdef RV32M_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       valid;
    logic       flush;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] aluop;
    logic [3:0] sel;
    logic       illegal;
    logic       stall;
    logic       mdstart;
    logic [2:0] mdop;
    logic       mddone;

    int checks = 0;
    int errors = 0;

    alu_md_sequencer #(
        .SEL_W(4), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .Valid(valid), .Flush(flush), .Op(op),
        .funct3(f3), .funct7(f7), .ALUOp(aluop), .Selection(sel),
        .Illegal(illegal), .Stall(stall), .MdStart(mdstart), .MdOp(mdop),
        .MdDone(mddone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder: table of the R/I-type base operations by funct3 with the two
    // funct7-dependent exceptions layered on top.
    function automatic logic [3:0] ref_sel(input logic [1:0] a, input logic [6:0] o,
                                           input logic [2:0] fn3, input logic [6:0] fn7);
        int tbl [8];
        tbl = '{0, 7, 5, 6, 4, 8, 3, 2};
        if (a == 2'd0) return 4'd0;
        if (a == 2'd1) return 4'd1;
        if (a == 2'd3) return 4'd15;
        if (o[5] == 1'b1 && fn7 == 7'd1) return MD_EN ? 4'd10 : 4'd15;
        if (fn3 == 3'd0 && o[5] && fn7[5]) return 4'd1;
        if (fn3 == 3'd5 && fn7[5]) return 4'd9;
        return 4'(tbl[fn3]);
    endfunction

    task automatic set_idle_inputs();
        valid = 1'b0; flush = 1'b0; op = 7'b0110011; f3 = 3'd0; f7 = 7'd0; aluop = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle_inputs();
        valid = 1'b1; aluop = 2'b10; f7 = 7'b0000001;
        #2;
        checks++;
        if (stall !== 1'b0 || mdstart !== 1'b0 || mddone !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stall=%b start=%b done=%b required 0/0/0", stall, mdstart, mddone);
        end
        checks++;
        if (mdop !== 3'b000) begin
            errors++;
            $display("FAIL reset_mdop: got %b required 000", mdop);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || mdstart !== 1'b0 || mddone !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: stall=%b start=%b done=%b required 0/0/0", stall, mdstart, mddone);
        end
        @(negedge clk);
        set_idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode_sweep();
        logic [3:0] e;
        logic [6:0] dop [4];
        logic [2:0] df3 [4];
        logic [6:0] df7 [4];
        logic [1:0] dal [4];
        logic [3:0] dex [4];
        dop = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110011};
        df3 = '{3'b000, 3'b101, 3'b000, 3'b000};
        df7 = '{7'b0100000, 7'b0100000, 7'b0100000, 7'b0000000};
        dal = '{2'b10, 2'b10, 2'b10, 2'b11};
        dex = '{4'b0001, 4'b1001, 4'b0000, 4'b1111};
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; flush = 1'b0;
            op = dop[i]; f3 = df3[i]; f7 = df7[i]; aluop = dal[i];
            #1;
            checks++;
            if (sel !== dex[i] || illegal !== (dex[i] == 4'd15)) begin
                errors++;
                $display("FAIL decode_directed[%0d]: sel=%b ill=%b required sel=%b ill=%b",
                         i, sel, illegal, dex[i], dex[i] == 4'd15);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 300; i++) begin
            int r;
            aluop = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            op = (r == 0) ? 7'b0110011 : (r == 1) ? 7'b0010011 : 7'($urandom);
            r = $urandom_range(0, 3);
            f7 = (r == 0) ? 7'd0 : (r == 1) ? 7'b0100000 : (r == 2) ? 7'b0000001 : 7'($urandom);
            f3 = 3'($urandom);
            valid = 1'($urandom);
            flush = 1'b0;
            e = ref_sel(aluop, op, f3, f7);
            if (e == 4'd10) valid = 1'b0;
            #1;
            checks++;
            if (sel !== e || illegal !== (valid && e == 4'd15) || stall !== 1'b0) begin
                errors++;
                $display("FAIL decode_rand[%0d]: sel=%b ill=%b stall=%b required sel=%b ill=%b stall=0",
                         i, sel, illegal, stall, e, valid && e == 4'd15);
            end
            @(posedge clk);
            #1;
            checks++;
            if (mdstart !== 1'b0 || mddone !== 1'b0) begin
                errors++;
                $display("FAIL decode_rand_md[%0d]: start=%b done=%b required 0/0", i, mdstart, mddone);
            end
        end
        set_idle_inputs();
    endtask

`ifdef RV32M_EN
    // Entered at the start of launch cycle 0; returns at the start of cycle n+2.
    task automatic run_md(input logic [2:0] fn3, input int n, input string tag);
        valid = 1'b1; flush = 1'b0; aluop = 2'b10; op = 7'b0110011; f3 = fn3; f7 = 7'b0000001;
        #1;
        checks++;
        if (sel !== 4'd10 || stall !== 1'b1 || mdstart !== 1'b0 || mddone !== 1'b0) begin
            errors++;
            $display("FAIL %s_launch: sel=%b stall=%b start=%b done=%b required 1010/1/0/0",
                     tag, sel, stall, mdstart, mddone);
        end
        for (int k = 1; k <= n + 1; k++) begin
            @(posedge clk);
            #1;
            valid = 1'($urandom);
            f3 = 3'($urandom);
            #1;
            checks++;
            if (stall !== (k <= n) || mdstart !== (k == 1) || mddone !== (k == n + 1) || mdop !== fn3) begin
                errors++;
                $display("FAIL %s_cycle%0d: stall=%b start=%b done=%b op=%b required %b/%b/%b/%b",
                         tag, k, stall, mdstart, mddone, mdop, k <= n, k == 1, k == n + 1, fn3);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (mdstart !== 1'b0 || mddone !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: start=%b done=%b required 0/0", tag, mdstart, mddone);
        end
        set_idle_inputs();
    endtask

    task automatic test_mul_div();
        run_md(3'b000, MUL_N, "mul");
        run_md(3'b100, DIV_N, "div");
        for (int i = 0; i < 4; i++) begin
            logic [2:0] r;
            r = 3'($urandom);
            run_md(r, r[2] ? DIV_N : MUL_N, "rand_md");
        end
    endtask

    task automatic test_back_to_back();
        run_md(3'b001, MUL_N, "b2b_first");
        run_md(3'b110, DIV_N, "b2b_second");
    endtask

    task automatic test_flush();
        valid = 1'b1; aluop = 2'b10; op = 7'b0110011; f3 = 3'b100; f7 = 7'b0000001;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mddone !== 1'b0) begin
            errors++;
            $display("FAIL flush_run: stall=%b done=%b required 0/0", stall, mddone);
        end
        for (int k = 0; k < DIV_N + 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mddone !== 1'b0 || mdstart !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet[%0d]: done=%b start=%b stall=%b required 0/0/0",
                         k, mddone, mdstart, stall);
            end
        end
        valid = 1'b1; aluop = 2'b10; op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000000;
        #1;
        checks++;
        if (sel !== 4'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_add: sel=%b stall=%b required 0000/0", sel, stall);
        end
        // Flush in the decode cycle of an MD instruction must cancel its launch.
        @(posedge clk);
        #1;
        f7 = 7'b0000001; flush = 1'b1;
        @(posedge clk);
        #1;
        set_idle_inputs();
        #1;
        checks++;
        if (mdstart !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: start=%b stall=%b required 0/0", mdstart, stall);
        end
    endtask

    task automatic test_reset_midrun();
        valid = 1'b1; aluop = 2'b10; op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000001;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || mdstart !== 1'b0 || mddone !== 1'b0 || mdop !== 3'b000) begin
            errors++;
            $display("FAIL rst_midrun: stall=%b start=%b done=%b op=%b required 0/0/0/000",
                     stall, mdstart, mddone, mdop);
        end
        @(posedge clk);
        #1;
        checks++;
        if (stall !== 1'b0 || mdstart !== 1'b0 || mddone !== 1'b0) begin
            errors++;
            $display("FAIL rst_midrun_hold: stall=%b start=%b done=%b required 0/0/0",
                     stall, mdstart, mddone);
        end
        @(negedge clk);
        set_idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < MUL_N + 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (mddone !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_done[%0d]: done=%b stall=%b required 0/0", k, mddone, stall);
            end
        end
        run_md(3'b000, MUL_N, "mul_after_rst");
    endtask
`else
    task automatic test_no_md();
        valid = 1'b1; flush = 1'b0; aluop = 2'b10; op = 7'b0110011; f3 = 3'b000; f7 = 7'b0000001;
        for (int k = 0; k < 8; k++) begin
            f3 = 3'($urandom);
            #1;
            checks++;
            if (sel !== 4'b1111 || illegal !== 1'b1 || stall !== 1'b0) begin
                errors++;
                $display("FAIL nomd_decode[%0d]: sel=%b ill=%b stall=%b required 1111/1/0",
                         k, sel, illegal, stall);
            end
            @(posedge clk);
            #1;
            checks++;
            if (mdstart !== 1'b0 || mddone !== 1'b0 || mdop !== 3'b000) begin
                errors++;
                $display("FAIL nomd_seq[%0d]: start=%b done=%b op=%b required 0/0/000",
                         k, mdstart, mddone, mdop);
            end
        end
        set_idle_inputs();
    endtask
`endif

    initial begin
        set_idle_inputs();
        rst = 1'b0;
        test_reset();
        test_decode_sweep();
`ifdef RV32M_EN
        test_mul_div();
        test_back_to_back();
        test_flush();
        test_reset_midrun();
`else
        test_no_md();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md_sequencer.md
# alu_md_sequencer

Parametrised successor to the ALU control decoder: decodes the full RV32I ALU operation set plus RV32M multiply/divide into a widened `Selection` code. It also sequences multi-cycle mul/div operations through a small state machine that stalls the single-cycle core. It sits between the main control unit (`ALUOp`) and the ALU/mul-div datapath.

## Interface
- `SEL_W`, 4: width of `Selection`; must be ≥ 4.
- `MUL_CYCLES`, 4: RUN-state cycles for MUL/MULH/MULHSU/MULHU; ≥ 1.
- `DIV_CYCLES`, 32: RUN-state cycles for DIV/DIVU/REM/REMU; ≥ 1.
- `CNT_W`, 6: cycle-counter width; must hold max(MUL_CYCLES, DIV_CYCLES) − 1.

- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `Valid`: input, 1 bit. Instruction in decode is valid.
- `Flush`: input, 1 bit. Synchronous abort of an in-flight mul/div.
- `Op`: input, 7 bits. Instruction opcode.
- `funct3`: input, 3 bits. Instruction funct3.
- `funct7`: input, 7 bits. Instruction funct7.
- `ALUOp`: input, 2 bits. From main control: 00 load/store, 01 branch, 10 R/I-type, 11 reserved.
- `Selection`: output, SEL_W bits. ALU operation code, combinational; upper bits beyond 4 are zero.
- `Illegal`: output, 1 bit. `Valid` high and decode gives 4'b1111.
- `Stall`: output, 1 bit. Hold PC and suppress register-file write.
- `MdStart`: output, 1 bit. One-cycle start pulse to the mul/div unit.
- `MdOp`: output, 3 bits. funct3 latched at mul/div launch.
- `MdDone`: output, 1 bit. One-cycle result-ready pulse; the core writes back this cycle.

## Operation
- Selection codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA
  - 1010 MD (mul/div result), 1111 illegal
  - Codes 0000–0011 and 0101 keep their prior meanings.
- Decode by `ALUOp`:
  - 00 → ADD; 01 → SUB; 11 → illegal.
  - 10, with `Op[5]`=1 and `funct7`=0000001 → MD (when enabled, see Configuration).
  - 10 otherwise, by funct3:
    - 000: SUB if {Op[5],funct7[5]}=11, else ADD
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR
    - 101: SRA if funct7[5]=1, else SRL
    - 110 OR; 111 AND
- `isMD` = `Valid` and decode gives MD.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if `isMD` → RUN. On that edge, load the counter with (funct3[2] ? DIV_CYCLES : MUL_CYCLES) − 1, latch `MdOp` ← funct3, and register `MdStart` ← 1.
  - RUN: the counter decrements each cycle. When the counter is 0 → DONE.
  - DONE: → IDLE unconditionally.
- `Stall` = (IDLE and `isMD`) or RUN. It is low in DONE.
- `MdDone` = 1 exactly in DONE.
- `Flush` high in RUN or DONE → IDLE next edge; `MdDone` is not produced. `Flush` in IDLE has no effect, and an `isMD` that cycle is suppressed (no launch).
- `Valid` or input changes during RUN/DONE are ignored by the FSM; the core holds the instruction because of `Stall`.
- Non-MD instructions never stall; `MdStart` and `MdDone` stay 0.

## Timing
- Decode path (`Selection`, `Illegal`) is purely combinational, with zero latency.
- MD instruction with N = MUL_CYCLES or DIV_CYCLES, where launch is cycle 0:
  - `Stall` is high cycles 0..N.
  - `MdStart` is high in cycle 1 only.
  - `MdDone` is high in cycle N+1.
  - Total occupancy is N+2 cycles.
- Back-to-back MD instructions: the second launch can occur no earlier than the cycle after DONE.
- Reset (`rst` low, async), all of the following hold immediately and persist until `rst` deasserts:
  - state IDLE, counter 0, `MdOp` 000
  - `MdStart` 0, `MdDone` 0
  - `Stall` forced 0
- Reset asserted mid-RUN aborts the operation; no `MdDone` is produced.

## Configuration
- `RV32M_EN` defined: MD decode and the sequencer are compiled in, as described above.
- `RV32M_EN` undefined:
  - `funct7`=0000001 with `ALUOp`=10 and `Op[5]`=1 decodes to 1111, so `Illegal`=1 when `Valid`.
  - FSM and counter are removed.
  - `Stall`, `MdStart` and `MdDone` are tied to 0; `MdOp` is tied to 000.

## Test plan
- Full decode sweep: `ALUOp`=10, `Op`=0110011, `funct7`=0100000, funct3=000 → 0001; funct3=101 → 1001; `Op`=0010011 with funct3=000 → 0000; `ALUOp`=11 → 1111 with `Illegal`=1.
- MUL (funct3=000, `funct7`=0000001, `Valid`=1) with defaults → `Stall` high 5 cycles, `MdStart` in cycle 1, `MdDone` in cycle 5, `MdOp`=000.
- DIV (funct3=100) → `Stall` high 33 cycles, `MdDone` in cycle 33, `MdOp`=100.
- `Flush` asserted in RUN cycle 3 of a DIV → IDLE next cycle, `Stall` low, no `MdDone`; then an ADD decodes 0000 with no stall.
- `rst` pulled low mid-RUN → `Stall`, `MdStart`, `MdDone` at 0 immediately; after release, a new MUL completes normally in 6 cycles.
- Build without `RV32M_EN`: MUL encoding → `Selection`=1111, `Illegal`=1, `Stall` stays 0.
